// File: rtl/tpu_pkg.sv
// Shared constants and types for the 2x2 TPU host streamer: batch geometry,
// byte positions within a batch for sent operands and returned results, FSM state.
package tpu_pkg;

  localparam int BATCH_LEN = 8;

  // Send order within a batch
  localparam logic [2:0] W0_IDX = 3'd0;
  localparam logic [2:0] W1_IDX = 3'd1;
  localparam logic [2:0] W2_IDX = 3'd2;
  localparam logic [2:0] W3_IDX = 3'd3;
  localparam logic [2:0] X0_IDX = 3'd4;
  localparam logic [2:0] X1_IDX = 3'd5;
  localparam logic [2:0] X2_IDX = 3'd6;
  localparam logic [2:0] X3_IDX = 3'(BATCH_LEN - 1);

  // Return order within a capture batch
  localparam logic [2:0] C00_HI_IDX = 3'd0;
  localparam logic [2:0] C00_LO_IDX = 3'd1;
  localparam logic [2:0] C01_HI_IDX = 3'd2;
  localparam logic [2:0] C01_LO_IDX = 3'd3;
  localparam logic [2:0] C10_HI_IDX = 3'd4;
  localparam logic [2:0] C10_LO_IDX = 3'd5;
  localparam logic [2:0] C11_HI_IDX = 3'd6;
  localparam logic [2:0] C11_LO_IDX = 3'(BATCH_LEN - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } streamer_state_e;

endpackage

// File: rtl/tpu_result_fifo.sv
// Small result FIFO with synchronous push/pop and a zero-when-empty head output.
module tpu_result_fifo
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == '0);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + AW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + AW'(1);
      end
      if (i_push && !i_pop) begin
        r_count <= r_count + CW'(1);
      end else if (i_pop && !i_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/tpu_host_streamer.sv
// Host-side byte-serial master for the 2x2 TPU: serialises jobs, captures results into a FIFO.
// Optional feature macro TPU_STREAMER_TRANSPOSE_EN adds cmd_transpose/transpose per-job flag.
module tpu_host_streamer
  import tpu_pkg::*;
#(
  parameter int RESULT_SLOTS = 1,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_w,
  input  logic [31:0] cmd_x,
`ifdef TPU_STREAMER_TRANSPOSE_EN
  input  logic        cmd_transpose,
  output logic        transpose,
`endif
  output logic        load_en,
  output logic [7:0]  host_indata,
  input  logic [7:0]  host_outdata,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [63:0] res_c
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  streamer_state_e         r_state;
  logic [2:0]              r_byte_idx;
  logic                    r_run;
  logic [CW-1:0]           r_credits;
  logic [31:0]             r_send_w;
  logic [31:0]             r_send_x;
  logic                    r_send_vld;
  logic [RESULT_SLOTS-1:0] r_slot;
  logic [63:0]             r_asm;
  logic                    r_push;

  logic w_accept;
  logic w_pop;
  logic w_batch_end;
  logic w_capture;
  logic w_fifo_full;
  logic w_fifo_empty;

  // r_run keeps cmd_ready low while reset is held and for the release cycle
  assign cmd_ready   = r_run && (r_credits < DEPTH_C) &&
                       ((r_state == ST_IDLE) || (r_byte_idx == X3_IDX));
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_pop       = res_valid && res_ready;
  assign w_batch_end = (r_state == ST_ACTIVE) && (r_byte_idx == X3_IDX);
  assign w_capture   = (r_state == ST_ACTIVE) && r_slot[RESULT_SLOTS-1];
  assign load_en     = (r_state == ST_ACTIVE);
  assign res_valid   = !w_fifo_empty;

  always_comb begin
    host_indata = 8'h00;
    case (r_byte_idx)
      W0_IDX: host_indata = r_send_w[7:0];
      W1_IDX: host_indata = r_send_w[15:8];
      W2_IDX: host_indata = r_send_w[23:16];
      W3_IDX: host_indata = r_send_w[31:24];
      X0_IDX: host_indata = r_send_x[7:0];
      X1_IDX: host_indata = r_send_x[15:8];
      X2_IDX: host_indata = r_send_x[23:16];
      X3_IDX: host_indata = r_send_x[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_byte_idx <= 3'd0;
      r_run      <= 1'b0;
      r_credits  <= '0;
      r_send_w   <= '0;
      r_send_x   <= '0;
      r_send_vld <= 1'b0;
      r_slot     <= '0;
      r_asm      <= '0;
      r_push     <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_push <= w_capture && (r_byte_idx == C11_LO_IDX);

      if (w_accept && !w_pop) begin
        r_credits <= r_credits + CW'(1);
      end else if (w_pop && !w_accept) begin
        r_credits <= r_credits - CW'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_ACTIVE;
            r_byte_idx <= W0_IDX;
          end
        end
        ST_ACTIVE: begin
          r_byte_idx <= r_byte_idx + 3'd1;
        end
      endcase

      // A batch with no accepted job is sent as zeros (bubble)
      if (w_accept || w_batch_end) begin
        r_send_w   <= w_accept ? cmd_w : '0;
        r_send_x   <= w_accept ? cmd_x : '0;
        r_send_vld <= w_accept;
      end

      if (w_batch_end) begin
        r_slot[0] <= r_send_vld;
        for (int i = 1; i < RESULT_SLOTS; i++) begin
          r_slot[i] <= r_slot[i-1];
        end
      end

      // r_asm is held as {c11,c10,c01,c00}; the push one cycle later reads the full word
      if (w_capture) begin
        case (r_byte_idx)
          C00_HI_IDX: r_asm[15:8]  <= host_outdata;
          C00_LO_IDX: r_asm[7:0]   <= host_outdata;
          C01_HI_IDX: r_asm[31:24] <= host_outdata;
          C01_LO_IDX: r_asm[23:16] <= host_outdata;
          C10_HI_IDX: r_asm[47:40] <= host_outdata;
          C10_LO_IDX: r_asm[39:32] <= host_outdata;
          C11_HI_IDX: r_asm[63:56] <= host_outdata;
          C11_LO_IDX: r_asm[55:48] <= host_outdata;
        endcase
      end
    end
  end

`ifdef TPU_STREAMER_TRANSPOSE_EN
  logic r_send_t;
  assign transpose = r_send_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_send_t <= 1'b0;
    end else if (w_accept || w_batch_end) begin
      r_send_t <= w_accept && cmd_transpose;
    end
  end
`endif

  tpu_result_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_push),
    .i_push_data (r_asm),
    .i_pop       (w_pop),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_head      (res_c)
  );

  // Credits cap in-flight plus stored results, so a push can never meet a full FIFO
  assert property (@(posedge clk) disable iff (!rst_n) !(r_push && w_fifo_full));

endmodule

// File: tb/tb_tpu_host_streamer.sv
// Scoreboard bench for tpu_host_streamer: an array model answers each send batch with its
// 2x2 matrix product RESULT_SLOTS batches later; a negedge monitor checks protocol and results.
module tb_tpu_host_streamer;
  localparam int RS = 1;
  localparam int FD = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_w = '0;
  logic [31:0] cmd_x = '0;
  logic        load_en;
  logic [7:0]  host_indata;
  logic [7:0]  host_outdata = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [63:0] res_c;
`ifdef TPU_STREAMER_TRANSPOSE_EN
  logic        cmd_transpose = 1'b0;
  logic        transpose;
`endif

  always #5 clk = ~clk;

  tpu_host_streamer #(.RESULT_SLOTS(RS), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_w        (cmd_w),
    .cmd_x        (cmd_x),
`ifdef TPU_STREAMER_TRANSPOSE_EN
    .cmd_transpose(cmd_transpose),
    .transpose    (transpose),
`endif
    .load_en      (load_en),
    .host_indata  (host_indata),
    .host_outdata (host_outdata),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_c        (res_c)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // C = W*X with W=[[w0,w1],[w2,w3]], X=[[x0,x1],[x2,x3]]; returns {c11,c10,c01,c00}
  function automatic logic [63:0] matmul(input logic [31:0] w, input logic [31:0] x);
    int a[4];
    int b[4];
    int c00, c01, c10, c11;
    byte t;
    for (int k = 0; k < 4; k++) begin
      t = w[8*k +: 8]; a[k] = t;
      t = x[8*k +: 8]; b[k] = t;
    end
    c00 = a[0]*b[0] + a[1]*b[2];
    c01 = a[0]*b[1] + a[1]*b[3];
    c10 = a[2]*b[0] + a[3]*b[2];
    c11 = a[2]*b[1] + a[3]*b[3];
    return {c11[15:0], c10[15:0], c01[15:0], c00[15:0]};
  endfunction

  // Return byte k of a result word: c00 hi, c00 lo, c01 hi, ... c11 lo
  function automatic logic [7:0] ret_byte(input logic [63:0] r, input int k);
    return r[16*(k/2) + ((k % 2 == 0) ? 8 : 0) +: 8];
  endfunction

  // ---------------- monitor / array model / scoreboard ----------------
  logic [63:0] sb_q[$];
  int          acc_q[$];
  logic [63:0] ret_q[$];
  int          cyc = 0;
  int          m_credits = 0;
  int          m_pos = 0;
  bit          m_active = 0;
  bit          m_run = 0;
  bit          m_cur_vld = 0;
  logic [63:0] m_cur_job = '0;
  logic [63:0] m_obs = '0;
  logic [63:0] m_ret = '0;
  int          n_results = 0;
  int          n_accepts = 0;
  bit          lat_check = 0;
  logic [63:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    bit hs;
    bit pop;
    int a;
    logic [63:0] e;
    if (!rst_n) begin
      chk("rst_load_en", {63'd0, load_en}, 64'd0);
      chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
      chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
      chk("rst_res_c", res_c, 64'd0);
      sb_q.delete(); acc_q.delete(); ret_q.delete();
      m_credits = 0; m_active = 0; m_pos = 0; m_run = 0;
      m_cur_vld = 0; m_cur_job = '0;
      host_outdata = 8'($urandom);
    end else begin
      chk("load_en", {63'd0, load_en}, {63'd0, m_active});
      chk("cmd_ready", {63'd0, cmd_ready},
          {63'd0, m_run && (m_credits < FD) && (!m_active || m_pos == 7)});
      hs  = cmd_valid && cmd_ready;
      pop = res_valid && res_ready;

      if (m_active) begin
        if (m_pos == 0) begin
          if (ret_q.size() >= RS) m_ret = ret_q.pop_front();
          else m_ret = {$urandom, $urandom};
        end
        m_obs[8*m_pos +: 8] = host_indata;
        host_outdata = ret_byte(m_ret, m_pos);
        if (m_pos == 7) begin
          chk("send_bytes", m_obs, m_cur_vld ? m_cur_job : 64'd0);
          // bubble batches answer with noise that must never be captured
          if (m_cur_vld) ret_q.push_back(matmul(m_obs[31:0], m_obs[63:32]));
          else ret_q.push_back({$urandom, $urandom});
        end
      end else begin
        host_outdata = 8'($urandom);
      end

      if (pop) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got %h expected no result at %0t", res_c, $time);
        end else begin
          e = sb_q.pop_front();
          a = acc_q.pop_front();
          chk("res_c", res_c, e);
          if (lat_check) chk("latency", 64'(cyc - a), 64'd18);
          last_res = res_c;
          n_results++;
        end
        m_credits--;
      end

      if (hs) begin
        sb_q.push_back(matmul(cmd_w, cmd_x));
        acc_q.push_back(cyc);
        m_credits++;
        n_accepts++;
      end

      if (m_active) begin
        if (m_pos == 7) begin
          m_pos = 0;
          m_cur_vld = hs;
          m_cur_job = hs ? {cmd_x, cmd_w} : 64'd0;
        end else begin
          m_pos++;
        end
      end else if (hs) begin
        m_active = 1;
        m_pos = 0;
        m_cur_vld = 1;
        m_cur_job = {cmd_x, cmd_w};
      end
      m_run = 1;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_job(input logic [31:0] w, input logic [31:0] x);
    bit done;
    done = 0;
    cmd_valid = 1'b1;
    cmd_w = w;
    cmd_x = x;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    cmd_w = $urandom;
    cmd_x = $urandom;
    chk("accept_in_time", {63'd0, done}, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb_q.size() != 0; i++) step();
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  logic [31:0] rw, rx;
  int          base;
  bit          rand_done;

  initial begin
    // 1: reset idle, release
    repeat (3) step();
    rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    chk("post_reset_ready", {63'd0, cmd_ready}, 64'd1);
    step();

    // 2: single directed job
    res_ready = 1'b1;
    lat_check = 1;
    base = n_results;
    send_job(32'h0403_0201, 32'h0807_0605);
    drain();
    chk("single_count", 64'(n_results - base), 64'd1);
    chk("single_res", last_res, 64'h0032_002B_0016_0013);

    // 3: negative results
    send_job(32'h00FF_00FE, 32'h0000_0005);
    drain();
    chk("neg_res", last_res, 64'h0000_FFFB_0000_FFF6);
    chk("neg_c00", {48'd0, last_res[15:0]}, 64'h0000_0000_0000_FFF6);

    // 4: back-to-back
    base = n_results;
    for (int j = 0; j < 4; j++) send_job($urandom, $urandom);
    drain();
    chk("b2b_count", 64'(n_results - base), 64'd4);

    // 5: backpressure holds off the third job until a pop
    lat_check = 0;
    res_ready = 1'b0;
    base = n_results;
    send_job($urandom, $urandom);
    send_job($urandom, $urandom);
    a_blk: begin
      int acc_base;
      acc_base = n_accepts;
      fork
        send_job($urandom, $urandom);
        begin
          repeat (40) step();
          chk("bp_blocked", 64'(n_accepts - acc_base), 64'd0);
          res_ready = 1'b1;
        end
      join
    end
    drain();
    chk("bp_count", 64'(n_results - base), 64'd3);

    // 6: one job followed by bubble batches
    lat_check = 1;
    base = n_results;
    send_job($urandom, $urandom);
    repeat (40) step();
    drain();
    chk("bubble_count", 64'(n_results - base), 64'd1);
    chk("bubble_load_en", {63'd0, load_en}, 64'd1);

    // random traffic with random backpressure
    lat_check = 0;
    rand_done = 0;
    base = n_results;
    fork
      begin
        for (int j = 0; j < 25; j++) begin
          rw = $urandom;
          rx = $urandom;
          send_job(rw, rx);
          repeat ($urandom_range(0, 10)) step();
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          step();
          res_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    res_ready = 1'b1;
    drain();
    chk("rand_count", 64'(n_results - base), 64'd25);

    // reset mid-batch with a job in flight, then recover
    send_job($urandom, $urandom);
    repeat (5) step();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step(); step();
    @(negedge clk);
    chk("post_reset2_ready", {63'd0, cmd_ready}, 64'd1);
    step();
    base = n_results;
    lat_check = 1;
    send_job($urandom, $urandom);
    drain();
    chk("recover_count", 64'(n_results - base), 64'd1);

    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
